// File: rtl/mod_ctrl_pkg.sv
// Shared constants for the modulator control path: default word geometry,
// commit-mode selectors and the channel map used by the modulator top.
package mod_ctrl_pkg;

  localparam int BYTE_W        = 8;
  localparam int WIDTH_DEFAULT = 32;
  localparam int NCH_DEFAULT   = 4;

  localparam int DEFER_IMMEDIATE = 0;
  localparam int DEFER_SYNC      = 1;

  typedef enum logic [1:0] {
    CH_FREQ  = 2'd0,
    CH_PHASE = 2'd1,
    CH_AMP   = 2'd2,
    CH_MODE  = 2'd3
  } ch_idx_e;

endpackage

// File: rtl/ctrl_reg_cell.sv
// One shadow/active word pair: byte-enabled writes land in the shadow,
// and load copies the pre-edge shadow value into the active word.
module ctrl_reg_cell
  import mod_ctrl_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [WIDTH/BYTE_W-1:0]     wr_be,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        load,
  output logic [WIDTH-1:0]            active
);

  localparam int NB = WIDTH / BYTE_W;

  logic [WIDTH-1:0] shadow;

  // Load and write share an edge: active takes the old shadow, shadow the new bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= RST_VAL;
      active <= RST_VAL;
    end else begin
      if (load) begin
        active <= shadow;
      end
      if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (wr_be[k]) begin
            shadow[k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ctrl_reg_bank.sv
// Double-buffered control-register bank: per-channel shadow words are moved
// to the active outputs atomically, immediately or on the next sync_tick.
module ctrl_reg_bank
  import mod_ctrl_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEFAULT,
  parameter int               NCH     = NCH_DEFAULT,
  parameter int               AW      = 2,
  parameter int               DEFER   = DEFER_SYNC,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH/8-1:0]      wr_be,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    commit_req,
  input  logic                    sync_tick,
  output logic [NCH*WIDTH-1:0]    data_out,
  output logic                    pending,
  output logic                    dirty,
  output logic                    commit_done,
  output logic                    wr_err
);

  localparam logic [AW:0] NCH_LIM = (AW+1)'(NCH);

  logic           addr_ok;
  logic           valid_wr;
  logic           xfer;
  logic [NCH-1:0] ch_sel;

  assign addr_ok  = {1'b0, wr_addr} < NCH_LIM;
  assign valid_wr = wr_en & addr_ok;

  generate
    if (DEFER != DEFER_IMMEDIATE) begin : g_sync
      assign xfer = (commit_req | pending) & sync_tick;

      // A request seen off-tick is remembered until the next tick moves the set.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pending <= 1'b0;
        end else if (xfer) begin
          pending <= 1'b0;
        end else if (commit_req) begin
          pending <= 1'b1;
        end
      end
    end else begin : g_imm
      logic unused_sync;
      assign unused_sync = sync_tick;
      assign xfer        = commit_req;
      assign pending     = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty       <= 1'b0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      if (valid_wr) begin
        dirty <= 1'b1;
      end else if (xfer) begin
        dirty <= 1'b0;
      end
      commit_done <= xfer;
      wr_err      <= wr_en & ~addr_ok;
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign ch_sel[i] = valid_wr && (wr_addr == AW'(i));

      ctrl_reg_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ch_sel[i]),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .load    (xfer),
        .active  (data_out[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Self-checking bench: an immediate-commit bank (NCH=4) and a deferred-commit
// bank (NCH=3, nonzero reset value) share stimulus and are checked against a word-level model.
module tb_ctrl_reg_bank;

  localparam logic [31:0] RST_IMM = 32'h0000_0000;
  localparam logic [31:0] RST_DEF = 32'h5A5A_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic         commit_req;
  logic         sync_tick;

  logic [127:0] imm_data;
  logic         imm_pending, imm_dirty, imm_done, imm_err;
  logic [95:0]  def_data;
  logic         def_pending, def_dirty, def_done, def_err;

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] m_shadow [2][4];
  logic [31:0] m_active [2][4];
  bit          m_pending [2];
  bit          m_dirty   [2];
  bit          m_done    [2];
  bit          m_err     [2];

  ctrl_reg_bank #(
    .WIDTH(32), .NCH(4), .AW(2), .DEFER(0), .RST_VAL(RST_IMM)
  ) dut_imm (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .commit_req(commit_req),
    .sync_tick(sync_tick), .data_out(imm_data), .pending(imm_pending),
    .dirty(imm_dirty), .commit_done(imm_done), .wr_err(imm_err)
  );

  ctrl_reg_bank #(
    .WIDTH(32), .NCH(3), .AW(2), .DEFER(1), .RST_VAL(RST_DEF)
  ) dut_def (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .commit_req(commit_req),
    .sync_tick(sync_tick), .data_out(def_data), .pending(def_pending),
    .dirty(def_dirty), .commit_done(def_done), .wr_err(def_err)
  );

  always #5 clk = ~clk;

  function automatic int nchOf(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [31:0] rstOf(input int d);
    return (d == 0) ? RST_IMM : RST_DEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_shadow[d][c] = rstOf(d);
        m_active[d][c] = rstOf(d);
      end
      m_pending[d] = 0;
      m_dirty[d]   = 0;
      m_done[d]    = 0;
      m_err[d]     = 0;
    end
  endtask

  // One clock edge of the behavioural bank, using the inputs present at the edge.
  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      bit ok;
      bit xf;
      ok = wr_en && (int'(wr_addr) < nchOf(d));
      if (d == 1) xf = (commit_req || m_pending[d]) && sync_tick;
      else        xf = commit_req;
      if (xf) begin
        for (int c = 0; c < 4; c++) m_active[d][c] = m_shadow[d][c];
      end
      if (ok) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) m_shadow[d][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
      m_pending[d] = (d == 1) && !xf && (commit_req || m_pending[d]);
      m_dirty[d]   = ok || (m_dirty[d] && !xf);
      m_done[d]    = xf;
      m_err[d]     = wr_en && !ok;
    end
  endtask

  task automatic compareAll();
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("imm_ch%0d", c), imm_data[c*32 +: 32], m_active[0][c]);
    for (int c = 0; c < 3; c++)
      checkOutput($sformatf("def_ch%0d", c), def_data[c*32 +: 32], m_active[1][c]);
    checkOutput("imm_pending", 32'(imm_pending), 32'(m_pending[0]));
    checkOutput("imm_dirty",   32'(imm_dirty),   32'(m_dirty[0]));
    checkOutput("imm_done",    32'(imm_done),    32'(m_done[0]));
    checkOutput("imm_err",     32'(imm_err),     32'(m_err[0]));
    checkOutput("def_pending", 32'(def_pending), 32'(m_pending[1]));
    checkOutput("def_dirty",   32'(def_dirty),   32'(m_dirty[1]));
    checkOutput("def_done",    32'(def_done),    32'(m_done[1]));
    checkOutput("def_err",     32'(def_err),     32'(m_err[1]));
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input logic cr, input logic st);
    wr_en      = we;
    wr_addr    = addr;
    wr_be      = be;
    wr_data    = data;
    commit_req = cr;
    sync_tick  = st;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 2'd0, 4'h0, 32'h0, 0, 0);
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible at once.
  task automatic doReset();
    wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; commit_req = 0; sync_tick = 0;
    reset_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    fail_count++;
    $display("[TB] FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b1;
    wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; commit_req = 0; sync_tick = 0;
    modelReset();
    #3;
    doReset();
    checkOutput("rst_imm_ch0", imm_data[31:0], 32'h0);
    checkOutput("rst_def_ch2", def_data[95:64], 32'h5A5A_0000);

    // Full-word write then immediate commit.
    applyStimulus(1, 2'd0, 4'hF, 32'h1234_5678, 0, 0);
    checkOutput("imm_dirty_set", 32'(imm_dirty), 32'd1);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    checkOutput("imm_ch0_commit", imm_data[31:0], 32'h1234_5678);
    checkOutput("imm_done_pulse", 32'(imm_done), 32'd1);
    checkOutput("imm_dirty_clr", 32'(imm_dirty), 32'd0);
    checkOutput("def_pending_set", 32'(def_pending), 32'd1);
    checkOutput("def_ch0_held", def_data[31:0], 32'h5A5A_0000);
    idle(1);
    checkOutput("imm_done_once", 32'(imm_done), 32'd0);

    // Partial byte-enable merge.
    applyStimulus(1, 2'd1, 4'hF, 32'hAABB_CCDD, 0, 0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    applyStimulus(1, 2'd1, 4'b0101, 32'h1122_3344, 0, 0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    checkOutput("imm_ch1_be", imm_data[63:32], 32'hAA22_CC44);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 0, 1);
    checkOutput("def_ch1_tick", def_data[63:32], 32'hAA22_CC44);
    checkOutput("def_ch0_tick", def_data[31:0], 32'h1234_5678);
    checkOutput("def_pending_clr", 32'(def_pending), 32'd0);

    // Deferred commit waits for the tick.
    applyStimulus(1, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    checkOutput("def_pend_ch2", 32'(def_pending), 32'd1);
    checkOutput("def_ch2_old", def_data[95:64], 32'h5A5A_0000);
    idle(5);
    checkOutput("def_still_pend", 32'(def_pending), 32'd1);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 0, 1);
    checkOutput("def_ch2_new", def_data[95:64], 32'hCAFE_F00D);
    checkOutput("def_done_pulse", 32'(def_done), 32'd1);
    checkOutput("def_pend_done", 32'(def_pending), 32'd0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 0, 1);
    checkOutput("def_tick_nopulse", 32'(def_done), 32'd0);

    // Write on a transfer edge; address 3 is out of range for the 3-channel bank.
    applyStimulus(1, 2'd3, 4'hF, 32'h0000_0001, 0, 0);
    checkOutput("def_wr_err", 32'(def_err), 32'd1);
    checkOutput("def_dirty_kept", 32'(def_dirty), 32'd0);
    checkOutput("imm_no_err", 32'(imm_err), 32'd0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    checkOutput("def_err_once", 32'(def_err), 32'd0);
    applyStimulus(1, 2'd3, 4'hF, 32'h0000_0002, 1, 0);
    checkOutput("imm_ch3_prewrite", imm_data[127:96], 32'h0000_0001);
    checkOutput("imm_dirty_sim", 32'(imm_dirty), 32'd1);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 1, 0);
    checkOutput("imm_ch3_second", imm_data[127:96], 32'h0000_0002);

    // Reset while a deferred commit and dirty shadows are outstanding.
    applyStimulus(1, 2'd0, 4'hF, 32'hDEAD_BEEF, 1, 0);
    checkOutput("def_pend_pre_rst", 32'(def_pending), 32'd1);
    checkOutput("def_dirty_pre_rst", 32'(def_dirty), 32'd1);
    doReset();
    checkOutput("rst_def_pend", 32'(def_pending), 32'd0);
    checkOutput("rst_def_ch0", def_data[31:0], 32'h5A5A_0000);
    checkOutput("rst_imm_ch3", imm_data[127:96], 32'h0);
    applyStimulus(0, 2'd0, 4'h0, 32'h0, 0, 1);
    checkOutput("rst_tick_nodone", 32'(def_done), 32'd0);
    checkOutput("rst_tick_ch0", def_data[31:0], 32'h5A5A_0000);

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ctrl_reg_bank.md
Name: ctrl_reg_bank

Overview:
Parametrised, double-buffered control-register bank for the modulator datapath. It holds the frequency, phase and amplitude words that feed the DDS/NCO and modulation-select logic. Writes land in per-channel shadow registers. The shadow set is copied to the active outputs atomically, either immediately on a commit request or deferred to the next symbol/accumulator-wrap tick, so that the modulator never sees a half-updated word set.

Parameters:
WIDTH, 32, bit width of each channel word; must be a multiple of 8.
NCH, 4, number of channels (1..16).
AW, 2, address width; 2**AW >= NCH.
DEFER, 1, 0 = commit on request, 1 = commit waits for sync_tick.
RST_VAL, 0, reset value of every shadow and active word (WIDTH bits).

Ports:
clk  in  1  clock.
reset_n  in  1  async active-low reset.
wr_en  in  1  write strobe, one word per cycle.
wr_addr  in  AW  channel index.
wr_be  in  WIDTH/8  byte enables for wr_data.
wr_data  in  WIDTH  write data.
commit_req  in  1  request shadow-to-active transfer (level sampled each edge).
sync_tick  in  1  symbol boundary / phase-accumulator wrap pulse.
data_out  out  NCH*WIDTH  active words; channel i at [i*WIDTH +: WIDTH].
pending  out  1  deferred commit waiting for sync_tick.
dirty  out  1  shadow differs in write history from active (a write since the last transfer).
commit_done  out  1  one-cycle pulse after each transfer.
wr_err  out  1  one-cycle pulse after a write to wr_addr >= NCH.

Behaviour:
- Reset: already decided. reset_n is asynchronous and active-low; clock is clk. On reset, all shadow and active words go to RST_VAL; pending, dirty, commit_done and wr_err go to 0. Reset mid-operation discards any pending commit and shadow contents.
- Write:
  - At an edge with wr_en=1 and wr_addr<NCH, shadow[wr_addr] byte k <= wr_data byte k for each k with wr_be[k]=1.
  - Bytes with wr_be[k]=0 are unchanged.
  - wr_be all 0 is a valid write that sets dirty but changes no data.
- Invalid address: wr_en=1 with wr_addr>=NCH leaves all shadow words unchanged, leaves dirty unchanged, and pulses wr_err high for the following cycle.
- Transfer condition (xfer):
  - DEFER=0: xfer = commit_req.
  - DEFER=1: xfer = (commit_req | pending) & sync_tick.
- Transfer action: at an edge with xfer=1, every active word <= its shadow value as held before that edge, all channels in the same edge. data_out updates one clock after commit_req (DEFER=0) or after the qualifying sync_tick (DEFER=1). commit_done is high for exactly the cycle following the transfer edge.
- Simultaneous write and transfer: the write updates shadow only; active receives the pre-write value; dirty stays/becomes 1.
- pending (DEFER=1 only; tied 0 when DEFER=0):
  - Set at an edge with commit_req=1 and sync_tick=0.
  - Cleared at a transfer edge.
  - Repeated commit_req while pending merges into one transfer.
  - commit_req together with sync_tick transfers on that edge, and pending stays 0.
- dirty:
  - Set by any valid write.
  - Cleared at a transfer edge unless a valid write occurs on the same edge.
- Transfer with dirty=0 is legal: active is unchanged in value and commit_done still pulses.
- sync_tick without a request causes no transfer and no pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (mod_ctrl_pkg): WIDTH default, NCH default, DEFER_IMMEDIATE=0 and DEFER_SYNC=1 constants, and channel index constants CH_FREQ=0, CH_PHASE=1, CH_AMP=2, CH_MODE=3 used by the modulator top.
- One natural sub-module: ctrl_reg_cell. It holds a single WIDTH-bit shadow and active register pair with a byte-enabled write and a load input, and is instantiated NCH times by a generate loop. Control logic (pending, dirty, xfer, commit_done, wr_err) stays in ctrl_reg_bank.

Test Plan:
- Reset then DEFER=0: write ch0=0x12345678 (be=4'hF), then commit_req for 1 cycle -> data_out[31:0]=0x12345678 one cycle later; commit_done pulses once; dirty 1->0.
- Byte enables: ch1 holds 0xAABBCCDD; write 0x11223344 with be=4'b0101, then commit -> ch1 active = 0xAA22CC44.
- DEFER=1: write ch2=0xCAFEF00D, then commit_req -> pending=1 and data_out unchanged. After 5 idle cycles, sync_tick -> ch2 active=0xCAFEF00D one cycle later, pending=0, commit_done pulses once.
- Simultaneous write and transfer: shadow ch3 holds 0x1, then write ch3=0x2 on the same edge as a transfer -> active ch3=0x1 and dirty=1; a second commit gives active ch3=0x2.
- Write wr_addr=3 with NCH=3 -> wr_err pulse one cycle; all shadows and dirty unchanged.
- Assert reset_n low while pending=1 with dirty shadows -> all outputs immediately RST_VAL/0. After release, sync_tick alone produces no commit_done.
